// File: rtl/proj_gfm_collector.sv
// proj_gfm_collector: reassembles FRAG_PART-bit GFM chunks from the projection
// extender into FRAG_LEN-bit fragment words. Each word is tagged with its signed
// start index and k-mer slot, then queued in a first-word-fall-through FIFO that
// drives a valid/ready handshake toward the signature/hash stage.
// Optional build macro: PROJ_GFM_COLLECTOR_PARITY_EN adds out_parity, the XOR
// reduction of the head word, computed at push time and stored per entry.

module proj_gfm_collector #(
    parameter int unsigned FRAG_LEN      = 8,
    parameter int unsigned FRAG_PART     = 2,
    parameter int unsigned INDICES_COUNT = 4,
    parameter int unsigned INDICE_LEN    = 5,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [FRAG_PART-1:0]             in_gfm,
    input  logic signed [INDICE_LEN:0]       in_index,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [FRAG_LEN-1:0]              out_word,
    output logic signed [INDICE_LEN:0]       out_index,
    output logic [$clog2(INDICES_COUNT)-1:0] out_kmer_sel,
    output logic [$clog2(FIFO_DEPTH):0]      out_count,
    output logic                             out_overflow
`ifdef PROJ_GFM_COLLECTOR_PARITY_EN
    ,
    output logic                             out_parity
`endif
);

    localparam int unsigned PARTS = FRAG_LEN / FRAG_PART;
    localparam int unsigned PW    = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int unsigned KW    = $clog2(INDICES_COUNT);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    localparam logic [PW-1:0] LastPart  = PW'(PARTS - 1);
    localparam logic [KW-1:0] LastKmer  = KW'(INDICES_COUNT - 1);
    localparam logic [AW:0]   FullCount = (AW + 1)'(FIFO_DEPTH);

    // Assembly state
    logic [PW-1:0]           part_cnt_q, part_cnt_d;
    logic [KW-1:0]           kmer_cnt_q, kmer_cnt_d;
    logic [FRAG_LEN-1:0]     word_q, word_d;
    logic signed [INDICE_LEN:0] index_q, index_d;

    // FIFO state
    logic [FRAG_LEN-1:0]     mem_word_q  [FIFO_DEPTH];
    logic [INDICE_LEN:0]     mem_index_q [FIFO_DEPTH];
    logic [KW-1:0]           mem_kmer_q  [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic                    overflow_q, overflow_d;

    logic [FRAG_LEN-1:0]     asm_word;
    logic signed [INDICE_LEN:0] asm_index;
    logic                    push_req, push_ok, pop;

`ifdef PROJ_GFM_COLLECTOR_PARITY_EN
    logic                    mem_par_q [FIFO_DEPTH];
`endif

    // Merge the incoming chunk into the partial word and decide push/pop for this edge
    always_comb begin
        asm_word = word_q;
        for (int unsigned j = 0; j < PARTS; j++) begin
            if (part_cnt_q == PW'(j)) begin
                asm_word[j*FRAG_PART +: FRAG_PART] = in_gfm;
            end
        end
        // With a single-part word the index arrives alongside the last chunk
        asm_index = (part_cnt_q == '0) ? in_index : index_q;

        push_req = in_valid && (part_cnt_q == LastPart);
        pop      = out_valid && out_ready;
        // A full FIFO still accepts the word when the head leaves on the same edge
        push_ok  = push_req && ((count_q != FullCount) || pop);

        part_cnt_d = part_cnt_q;
        kmer_cnt_d = kmer_cnt_q;
        word_d     = word_q;
        index_d    = index_q;
        if (in_valid) begin
            word_d = asm_word;
            if (part_cnt_q == '0) begin
                index_d = in_index;
            end
            if (push_req) begin
                part_cnt_d = '0;
                // Slot advances even on a dropped word to keep slot alignment
                kmer_cnt_d = (kmer_cnt_q == LastKmer) ? '0 : kmer_cnt_q + 1'b1;
            end else begin
                part_cnt_d = part_cnt_q + 1'b1;
            end
        end

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (push_req & ~push_ok);
    end

    // Register assembly and FIFO control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            part_cnt_q <= '0;
            kmer_cnt_q <= '0;
            word_q     <= '0;
            index_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            part_cnt_q <= part_cnt_d;
            kmer_cnt_q <= kmer_cnt_d;
            word_q     <= word_d;
            index_q    <= index_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Write the completed word and its tags into the FIFO storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_word_q[i]  <= '0;
                mem_index_q[i] <= '0;
                mem_kmer_q[i]  <= '0;
`ifdef PROJ_GFM_COLLECTOR_PARITY_EN
                mem_par_q[i]   <= 1'b0;
`endif
            end
        end else if (push_ok) begin
            mem_word_q[wr_ptr_q]  <= asm_word;
            mem_index_q[wr_ptr_q] <= asm_index;
            mem_kmer_q[wr_ptr_q]  <= kmer_cnt_q;
`ifdef PROJ_GFM_COLLECTOR_PARITY_EN
            mem_par_q[wr_ptr_q]   <= ^asm_word;
`endif
        end
    end

    // Present the FIFO head; all fields read zero while empty
    always_comb begin
        out_valid    = (count_q != '0);
        out_count    = count_q;
        out_overflow = overflow_q;
        out_word     = out_valid ? mem_word_q[rd_ptr_q] : '0;
        out_index    = out_valid ? mem_index_q[rd_ptr_q] : '0;
        out_kmer_sel = out_valid ? mem_kmer_q[rd_ptr_q] : '0;
`ifdef PROJ_GFM_COLLECTOR_PARITY_EN
        out_parity   = out_valid ? mem_par_q[rd_ptr_q] : 1'b0;
`endif
    end

endmodule

// File: tb/tb_proj_gfm_collector.sv
// Self-checking bench for proj_gfm_collector: directed scenarios followed by
// random traffic, compared every cycle against a queue-based reference model.

module tb_proj_gfm_collector;

    localparam int FL    = 8;
    localparam int FP    = 2;
    localparam int IC    = 4;
    localparam int IL    = 5;
    localparam int DEPTH = 4;
    localparam int PARTS = FL / FP;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic [FP-1:0]         in_gfm = '0;
    logic signed [IL:0]    in_index = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [FL-1:0]         out_word;
    logic signed [IL:0]    out_index;
    logic [1:0]            out_kmer_sel;
    logic [2:0]            out_count;
    logic                  out_overflow;
`ifdef PROJ_GFM_COLLECTOR_PARITY_EN
    logic                  out_parity;
`endif

    proj_gfm_collector #(
        .FRAG_LEN(FL), .FRAG_PART(FP), .INDICES_COUNT(IC), .INDICE_LEN(IL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_gfm(in_gfm), .in_index(in_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_index(out_index), .out_kmer_sel(out_kmer_sel), .out_count(out_count),
        .out_overflow(out_overflow)
`ifdef PROJ_GFM_COLLECTOR_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FL-1:0]      w;
        logic signed [IL:0] idx;
        logic [1:0]         k;
    } ent_t;

    ent_t               mq[$];
    int                 chunks[$];
    logic signed [IL:0] m_idx;
    int                 m_kmer;
    bit                 m_ovf;
    int                 errors = 0;
    int                 checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        chunks.delete();
        m_idx  = '0;
        m_kmer = 0;
        m_ovf  = 1'b0;
    endtask

    // Reference behaviour for one clock edge
    task automatic model_step(input bit v, input int g, input logic signed [IL:0] ix,
                              input bit rdy);
        ent_t e;
        logic [FL-1:0] w;
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (v) begin
            if (chunks.size() == 0) m_idx = ix;
            chunks.push_back(g);
            if (chunks.size() == PARTS) begin
                w = '0;
                for (int j = 0; j < PARTS; j++) w = w | (FL'(chunks[j]) << (FP * j));
                e.w = w; e.idx = m_idx; e.k = 2'(m_kmer);
                if (mq.size() < DEPTH) mq.push_back(e);
                else m_ovf = 1'b1;
                m_kmer = (m_kmer + 1) % IC;
                chunks.delete();
            end
        end
    endtask

    task automatic check_all();
        ent_t h;
        bit   v;
        v = (mq.size() > 0);
        if (v) h = mq[0];
        else begin h.w = '0; h.idx = '0; h.k = '0; end
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("out_count", 32'(out_count), 32'(mq.size()));
        chk("out_word", 32'(out_word), 32'(h.w));
        chk("out_index", 32'(out_index), 32'(h.idx));
        chk("out_kmer_sel", 32'(out_kmer_sel), 32'(h.k));
        chk("out_overflow", 32'(out_overflow), 32'(m_ovf));
`ifdef PROJ_GFM_COLLECTOR_PARITY_EN
        chk("out_parity", 32'(out_parity), 32'(v ? ^h.w : 1'b0));
`endif
    endtask

    task automatic cycle(input bit v, input logic [FP-1:0] g, input logic signed [IL:0] ix,
                         input bit rdy);
        in_valid  = v;
        in_gfm    = g;
        in_index  = ix;
        out_ready = rdy;
        @(posedge clk);
        model_step(v, int'(g), ix, rdy);
        #1;
        check_all();
    endtask

    // Reset with busy-looking inputs to show they are ignored
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_gfm    = FP'($urandom);
        in_index  = (IL + 1)'($urandom);
        out_ready = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_all();
    endtask

    // Send one word LSB chunk first; later-chunk index values are random noise
    task automatic send_word(input logic [FL-1:0] w, input logic signed [IL:0] ix,
                             input bit rdy, input int gap);
        logic [FP-1:0] g;
        for (int j = 0; j < PARTS; j++) begin
            g = w[j*FP +: FP];
            cycle(1'b1, g, (j == 0) ? ix : (IL + 1)'($urandom), rdy);
            for (int k = 0; k < gap; k++) cycle(1'b0, FP'($urandom), (IL + 1)'($urandom), rdy);
        end
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_count", 32'(out_count), 32'd0);

        // First word: chunks 01,10,11,00 with index -3
        send_word(8'h39, -6'sd3, 1'b0, 0);
        chk("tp1_word", 32'(out_word), 32'h39);
        chk("tp1_index", 32'(out_index), 32'(-6'sd3));
        chk("tp1_kmer", 32'(out_kmer_sel), 32'd0);
        chk("tp1_count", 32'(out_count), 32'd1);

        // Five words streamed with out_ready held high: slot wraps
        do_reset();
        for (int n = 0; n < 5; n++) begin
            send_word(FL'($urandom), (IL + 1)'($urandom), 1'b1, 0);
            chk("wrap_kmer", 32'(out_kmer_sel), 32'(n % IC));
        end
        cycle(1'b0, '0, '0, 1'b1);

        // Overflow: five words with no consumer
        do_reset();
        for (int n = 0; n < 5; n++) send_word(FL'($urandom), (IL + 1)'($urandom), 1'b0, 0);
        chk("ovf_count", 32'(out_count), 32'd4);
        chk("ovf_flag", 32'(out_overflow), 32'd1);
        for (int n = 0; n < 5; n++) cycle(1'b0, '0, '0, 1'b1);
        chk("ovf_drained", 32'(out_valid), 32'd0);
        send_word(FL'($urandom), (IL + 1)'($urandom), 1'b0, 0);
        chk("ovf_next_kmer", 32'(out_kmer_sel), 32'd1);

        // Full FIFO with a pop on the same edge as the last chunk
        do_reset();
        for (int n = 0; n < 4; n++) send_word(FL'($urandom), (IL + 1)'($urandom), 1'b0, 0);
        cycle(1'b1, 2'b10, 6'sd7, 1'b0);
        cycle(1'b1, 2'b01, 6'sd0, 1'b0);
        cycle(1'b1, 2'b11, 6'sd0, 1'b0);
        cycle(1'b1, 2'b00, 6'sd0, 1'b1);
        chk("fullpop_count", 32'(out_count), 32'd4);
        chk("fullpop_ovf", 32'(out_overflow), 32'd0);
        for (int n = 0; n < 5; n++) cycle(1'b0, '0, '0, 1'b1);

        // Reset in the middle of a word discards the partial chunks
        cycle(1'b1, 2'b11, 6'sd9, 1'b0);
        cycle(1'b1, 2'b11, 6'sd0, 1'b0);
        do_reset();
        send_word(8'hA5, -6'sd1, 1'b0, 0);
        chk("midrst_word", 32'(out_word), 32'hA5);
        chk("midrst_kmer", 32'(out_kmer_sel), 32'd0);

        // Three idle cycles between chunks: 11,11,01,00 index 5
        do_reset();
        send_word(8'h1F, 6'sd5, 1'b0, 3);
        chk("gap_word", 32'(out_word), 32'h1F);
        chk("gap_index", 32'(out_index), 32'd5);
`ifdef PROJ_GFM_COLLECTOR_PARITY_EN
        chk("gap_parity", 32'(out_parity), 32'd1);
`endif

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle($urandom_range(0, 9) < 7, FP'($urandom), (IL + 1)'($urandom),
                       $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
